proj1_alu_seq: RTL and testbench

Instruction sequencer and register file that drives the proj1 ALU from the initiator side. It accepts one instruction at a time over a valid/ready handshake and reads the two operands from an 8 x 8-bit register file. It presents the operands, carry-in and opcode to the ALU, waits out the ALU's fixed registered latency, then writes the result back and updates the status flags C, N and Z. It sits between the instruction source (or testbench) and the ALU.

---
 rtl/proj1_alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_proj1_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proj1_alu_seq.sv
// proj1_alu_seq
// Instruction sequencer and 8 x 8-bit register file that drives the proj1 ALU.
// One instruction is accepted at a time over instr_valid/instr_ready. Its
// operands are read from the register file and registered onto the alu_*
// outputs. The sequencer then waits out the ALU's fixed latency and writes the
// result back, updating the {C,N,Z} status flags.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   instr_valid/instr_ready   instruction handshake (ready only while idle)
//   instr_op/rd/rr            opcode, destination/operand A index, operand B index
//   wr_en/wr_addr/wr_data     direct register preload, usable in any state
//   rd_addr/rd_data           combinational debug read of the register file
//   sreg                      status flags {C,N,Z}
//   done                      one-cycle pulse after a completed writeback
//   err                       one-cycle pulse after an illegal opcode is taken
//   alu_data_rd/rr/ci/opcode  registered operands, carry-in and opcode to the ALU
//   alu_data_o, alu_co/no/zo  ALU result and flags, sampled on the writeback edge
module proj1_alu_seq #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [7:0]  instr_op,
  input  logic [2:0]  instr_rd,
  input  logic [2:0]  instr_rr,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [2:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [2:0]  sreg,
  output logic        done,
  output logic        err,
  output logic [7:0]  alu_data_rd,
  output logic [7:0]  alu_data_rr,
  output logic        alu_ci,
  output logic [7:0]  alu_opcode,
  input  logic [15:0] alu_data_o,
  input  logic        alu_co,
  input  logic        alu_no,
  input  logic        alu_zo
);

  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WB
  } state_t;

  // How the writeback treats the result and flags.
  typedef enum logic [1:0] {
    CLS_ARITH,   // shifts and add/addc/sub/subc: all flags from the ALU
    CLS_MULT,    // 16-bit result into a register pair, N kept
    CLS_LOGIC    // and/or/xor/neg: N,Z derived locally, C kept
  } op_class_t;

  state_t    state_q, state_d;
  op_class_t op_class, cls_q;
  logic      op_legal;

  logic [7:0]    regs [8];
  logic [CW-1:0] cnt_q;
  logic [2:0]    rd_q;
  logic          c_q, n_q, z_q;

  assign rd_data = regs[rd_addr];
  assign sreg    = {c_q, n_q, z_q};

  // Opcode decode into legality and writeback class.
  always_comb begin
    op_legal = 1'b0;
    op_class = CLS_ARITH;
    casez (instr_op)
      8'b0000_????: begin op_legal = 1'b1; op_class = CLS_ARITH; end
      8'b0100_????: begin op_legal = 1'b1; op_class = CLS_MULT;  end
      8'b1000_????,
      8'b1001_????,
      8'b1010_????,
      8'b1011_??00: begin op_legal = 1'b1; op_class = CLS_LOGIC; end
      8'b11??_????: begin op_legal = 1'b1; op_class = CLS_ARITH; end
      default:      begin op_legal = 1'b0; op_class = CLS_ARITH; end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state. The counter is loaded with ALU_LAT and WAIT hands over to WB
  // on the edge where it reaches zero, so the writeback edge lands exactly
  // ALU_LAT+1 edges after the accept edge.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && op_legal) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= CW'(1)) state_d = S_WB;
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, latency counter, register file and flags.
  // The preload write is issued before the writeback writes so that a
  // writeback to the same register overrides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      cnt_q       <= '0;
      rd_q        <= 3'd0;
      cls_q       <= CLS_ARITH;
      alu_data_rd <= 8'h00;
      alu_data_rr <= 8'h00;
      alu_ci      <= 1'b0;
      alu_opcode  <= 8'h00;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (wr_en) regs[wr_addr] <= wr_data;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            if (op_legal) begin
              alu_data_rd <= regs[instr_rd];
              alu_data_rr <= regs[instr_rr];
              alu_ci      <= c_q;
              alu_opcode  <= instr_op;
              rd_q        <= instr_rd;
              cls_q       <= op_class;
              cnt_q       <= CW'(ALU_LAT);
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
        end
        S_WB: begin
          done       <= 1'b1;
          regs[rd_q] <= alu_data_o[7:0];
          case (cls_q)
            CLS_MULT: begin
              regs[rd_q + 3'd1] <= alu_data_o[15:8];
              c_q <= alu_co;
              z_q <= alu_zo;
            end
            CLS_LOGIC: begin
              n_q <= alu_data_o[7];
              z_q <= (alu_data_o[7:0] == 8'h00);
            end
            default: begin
              c_q <= alu_co;
              n_q <= alu_no;
              z_q <= alu_zo;
            end
          endcase
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proj1_alu_seq.sv
// tb_proj1_alu_seq
// Directed bench for proj1_alu_seq. The ALU side is driven directly by the
// bench with hand-chosen result/flag values for each instruction; every
// expected value below is worked out by hand from the sequencer's behaviour.
module tb_proj1_alu_seq;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_op;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic [2:0]  sreg;
  logic        done;
  logic        err;
  logic [7:0]  alu_data_rd;
  logic [7:0]  alu_data_rr;
  logic        alu_ci;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_data_o;
  logic        alu_co;
  logic        alu_no;
  logic        alu_zo;

  int checks = 0;
  int errors = 0;
  int acc[$];

  proj1_alu_seq #(.ALU_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rr    (instr_rr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .sreg        (sreg),
    .done        (done),
    .err         (err),
    .alu_data_rd (alu_data_rd),
    .alu_data_rr (alu_data_rr),
    .alu_ci      (alu_ci),
    .alu_opcode  (alu_opcode),
    .alu_data_o  (alu_data_o),
    .alu_co      (alu_co),
    .alu_no      (alu_no),
    .alu_zo      (alu_zo)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    rd_addr = idx;
    #1;
    checkOutput(tag, 16'(rd_data), 16'(exp));
  endtask

  task automatic preload(input logic [2:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic setAlu(input logic [15:0] data, input logic co, input logic no, input logic zo);
    alu_data_o = data;
    alu_co     = co;
    alu_no     = no;
    alu_zo     = zo;
  endtask

  // Present one instruction for one cycle; returns 1 ns after its accept edge.
  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rr);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rr    = rr;
    tick();
    instr_valid = 1'b0;
  endtask

  // From 1 ns after the accept edge, run through the writeback edge (E0+3).
  task automatic finishInstr(input string tag);
    tick();
    tick();
    tick();
    checkOutput(tag, 16'(done), 16'(1'b1));
  endtask

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 8'h00;
    instr_rd    = 3'd0;
    instr_rr    = 3'd0;
    wr_en       = 1'b0;
    wr_addr     = 3'd0;
    wr_data     = 8'h00;
    rd_addr     = 3'd0;
    setAlu(16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_ready", 16'(instr_ready), 16'(1'b1));
    checkOutput("rst_sreg", 16'(sreg), 16'(3'b000));
    checkOutput("rst_done", 16'(done), 16'(1'b0));
    checkOutput("rst_err", 16'(err), 16'(1'b0));
    checkOutput("rst_opcode", 16'(alu_opcode), 16'h0000);
    checkOutput("rst_data_rd", 16'(alu_data_rd), 16'h0000);
    checkReg("rst_r3", 3'd3, 8'h00);

    // add R1=0x30 + R2=0x05, with a preload of R2 during WAIT and a colliding
    // preload of R1 on the writeback edge.
    $display("[TB] add with preload collisions");
    preload(3'd1, 8'h30);
    preload(3'd2, 8'h05);
    setAlu(16'h0035, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hC0, 3'd1, 3'd2);
    checkOutput("add_data_rd", 16'(alu_data_rd), 16'h0030);
    checkOutput("add_data_rr", 16'(alu_data_rr), 16'h0005);
    checkOutput("add_opcode", 16'(alu_opcode), 16'h00C0);
    checkOutput("add_ci", 16'(alu_ci), 16'(1'b0));
    checkOutput("add_busy", 16'(instr_ready), 16'(1'b0));
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    checkOutput("add_rr_held", 16'(alu_data_rr), 16'h0005);
    checkOutput("add_done_e1", 16'(done), 16'(1'b0));
    checkReg("add_r2_preload", 3'd2, 8'h77);
    tick();
    checkOutput("add_done_e2", 16'(done), 16'(1'b0));
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    checkOutput("add_done_e3", 16'(done), 16'(1'b1));
    checkOutput("add_ready_e3", 16'(instr_ready), 16'(1'b1));
    checkReg("add_r1_wb_wins", 3'd1, 8'h35);
    checkOutput("add_sreg", 16'(sreg), 16'(3'b000));
    tick();
    checkOutput("add_done_pulse", 16'(done), 16'(1'b0));

    // sub: all flags from the ALU -> C=1, N=1, Z=0.
    $display("[TB] sub");
    preload(3'd5, 8'h70);
    setAlu(16'h00F0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'hE0, 3'd5, 3'd5);
    finishInstr("sub_done");
    checkReg("sub_r5", 3'd5, 8'hF0);
    checkOutput("sub_sreg", 16'(sreg), 16'(3'b110));

    // xor R4,R4: ALU flags are contradicting on purpose; N/Z come from the
    // result, C stays 1.
    $display("[TB] xor flags");
    preload(3'd4, 8'hA5);
    setAlu(16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'hA0, 3'd4, 3'd4);
    checkOutput("xor_data_rd", 16'(alu_data_rd), 16'h00A5);
    checkOutput("xor_data_rr", 16'(alu_data_rr), 16'h00A5);
    checkOutput("xor_ci", 16'(alu_ci), 16'(1'b1));
    finishInstr("xor_done");
    checkReg("xor_r4", 3'd4, 8'h00);
    checkOutput("xor_sreg", 16'(sreg), 16'(3'b101));

    // rol with C=1: carry-in must reach the ALU; result sets N.
    $display("[TB] rol");
    setAlu(16'h0081, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h01, 3'd6, 3'd6);
    checkOutput("rol_ci", 16'(alu_ci), 16'(1'b1));
    finishInstr("rol_done");
    checkReg("rol_r6", 3'd6, 8'h81);
    checkOutput("rol_sreg", 16'(sreg), 16'(3'b010));

    // mult R7*R3 with rd=7: high byte wraps into R0, N kept at 1.
    $display("[TB] mult wrap");
    preload(3'd7, 8'h10);
    preload(3'd3, 8'h20);
    setAlu(16'h0200, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h40, 3'd7, 3'd3);
    checkOutput("mul_ci", 16'(alu_ci), 16'(1'b0));
    checkOutput("mul_data_rd", 16'(alu_data_rd), 16'h0010);
    checkOutput("mul_data_rr", 16'(alu_data_rr), 16'h0020);
    finishInstr("mul_done");
    checkReg("mul_r7", 3'd7, 8'h00);
    checkReg("mul_r0", 3'd0, 8'h02);
    checkOutput("mul_sreg", 16'(sreg), 16'(3'b010));

    // Illegal opcodes: err pulses, nothing else moves.
    $display("[TB] illegal opcodes");
    applyStimulus(8'h20, 3'd1, 3'd2);
    checkOutput("ill_err", 16'(err), 16'(1'b1));
    checkOutput("ill_ready", 16'(instr_ready), 16'(1'b1));
    checkOutput("ill_opcode", 16'(alu_opcode), 16'h0040);
    checkOutput("ill_data_rd", 16'(alu_data_rd), 16'h0010);
    tick();
    checkOutput("ill_err_pulse", 16'(err), 16'(1'b0));
    checkOutput("ill_done", 16'(done), 16'(1'b0));
    checkOutput("ill_sreg", 16'(sreg), 16'(3'b010));
    checkReg("ill_r1", 3'd1, 8'h35);
    applyStimulus(8'hB1, 3'd1, 3'd2);
    checkOutput("ill_neg_err", 16'(err), 16'(1'b1));
    checkOutput("ill_neg_opcode", 16'(alu_opcode), 16'h0040);
    tick();

    // neg 1011xx00 is legal; locally derived flags ignore the ALU's N/Z.
    $display("[TB] neg");
    setAlu(16'h005B, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'hB4, 3'd5, 3'd5);
    checkOutput("neg_err", 16'(err), 16'(1'b0));
    checkOutput("neg_busy", 16'(instr_ready), 16'(1'b0));
    checkOutput("neg_opcode", 16'(alu_opcode), 16'h00B4);
    finishInstr("neg_done");
    checkReg("neg_r5", 3'd5, 8'h5B);
    checkOutput("neg_sreg", 16'(sreg), 16'(3'b000));

    // Back-to-back: valid held high, accepts must be 4 cycles apart.
    $display("[TB] back-to-back");
    setAlu(16'h0011, 1'b0, 1'b0, 1'b0);
    instr_valid = 1'b1;
    instr_op    = 8'hC0;
    instr_rd    = 3'd2;
    instr_rr    = 3'd2;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) acc.push_back(i);
      tick();
    end
    instr_valid = 1'b0;
    checkOutput("b2b_count", 16'(acc.size()), 16'd3);
    if (acc.size() == 3) begin
      checkOutput("b2b_gap1", 16'(acc[1] - acc[0]), 16'd4);
      checkOutput("b2b_gap2", 16'(acc[2] - acc[1]), 16'd4);
    end
    tick();
    tick();
    tick();
    checkOutput("b2b_last_done", 16'(done), 16'(1'b1));
    tick();

    // Reset in the middle of a mult's WAIT: everything clears, no done.
    $display("[TB] reset mid-operation");
    setAlu(16'hFFFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h40, 3'd7, 3'd3);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("mrst_ready", 16'(instr_ready), 16'(1'b1));
    checkOutput("mrst_sreg", 16'(sreg), 16'(3'b000));
    checkOutput("mrst_data_rd", 16'(alu_data_rd), 16'h0000);
    checkOutput("mrst_data_rr", 16'(alu_data_rr), 16'h0000);
    checkOutput("mrst_opcode", 16'(alu_opcode), 16'h0000);
    checkOutput("mrst_done", 16'(done), 16'(1'b0));
    for (int r = 0; r < 8; r++) begin
      checkReg($sformatf("mrst_r%0d", r), 3'(r), 8'h00);
    end
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("mrst_no_done_%0d", k), 16'(done), 16'(1'b0));
    end
    checkReg("mrst_r7_after", 3'd7, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
